// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the buffered UART transmitter.
//   - FSM state encodings (kept as plain logic constants for compatibility
//     with older blocks that compare against raw values)
//   - data-width select encodings for cfg_data_bits
//   - MIN_DIV: smallest usable clocks-per-bit value
//   - data_parity(): XOR of the active data bits for a given width select
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam int MIN_DIV = 2;

  // Even parity over data[n-1:0], n = 5 + dbits.
  function automatic logic data_parity(input logic [7:0] data, input logic [1:0] dbits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 5 + int'(dbits)) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through read.
//   i_wr_en/i_wr_data : write request; ignored while full
//   i_rd_en           : pop request; ignored while empty
//   o_rd_data         : head entry, valid whenever !o_empty
//   o_full/o_empty    : occupancy flags, decoded from the registered level
//   o_level           : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap without compare logic.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rptr];

  assign w_push = i_wr_en && !o_full;
  assign w_pop  = i_rd_en && !o_empty;

  // Storage needs no reset: contents are unreachable once the level is zero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: buffered UART transmitter with runtime frame format.
//   clk, resetn      : system clock, async active-low reset
//   cfg_div          : clocks per bit (values below 2 behave as 2)
//   cfg_data_bits    : 00=5, 01=6, 10=7, 11=8 data bits
//   cfg_parity_en    : append parity bit
//   cfg_parity_odd   : odd (1) / even (0) parity
//   cfg_stop2        : two stop bits
//   s_valid/s_data   : byte push stream, accepted when s_ready is high
//   s_ready          : FIFO has room (depends only on registered level)
//   fifo_level       : bytes waiting in the FIFO
//   tx_busy          : frame in progress
//   uart_tx          : registered serial line, idle high
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high; pop and latch config as soon as FIFO non-empty
// ST_START  | start bit (0) for div cycles
// ST_DATA   | n data bits LSB first, div cycles each
// ST_PARITY | parity bit for div cycles (only when enabled)
// ST_STOP   | 1 or 2 stop bits; last cycle pops the next byte if present
//
// uart_tx is the registered image of the current state, so the line trails
// the state register by one cycle; tx_busy is decoded straight from state.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  output logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          uart_tx
);

  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_rd_data;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_tick;
  logic             w_last_stop;
  logic             w_frame_end;
  logic             w_pop;
  logic             w_line;

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [2:0]       r_last_bit;
  logic [7:0]       r_shift;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_stop2;
  logic             r_tx;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_wr_en   (s_valid),
    .i_wr_data (s_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );

  assign s_ready = !w_full;
  assign tx_busy = (r_state != ST_IDLE);
  assign uart_tx = r_tx;

  assign w_div_eff   = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
  assign w_tick      = (r_cnt == r_div - DIV_W'(1));
  assign w_last_stop = (r_bit == {2'b00, r_stop2});
  assign w_frame_end = (r_state == ST_STOP) && w_tick && w_last_stop;
  // Popping on the final stop cycle chains frames with no idle gap.
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_frame_end);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_div      <= DIV_W'(MIN_DIV);
      r_bit      <= '0;
      r_last_bit <= 3'd7;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
    end else if (w_pop) begin
      // Frame shadow: config changes after this point only affect later frames.
      r_state    <= ST_START;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_div      <= w_div_eff;
      r_last_bit <= 3'd4 + {1'b0, cfg_data_bits};
      r_shift    <= w_rd_data;
      r_par_en   <= cfg_parity_en;
      r_par_bit  <= data_parity(w_rd_data, cfg_data_bits) ^ cfg_parity_odd;
      r_stop2    <= cfg_stop2;
    end else if (r_state != ST_IDLE) begin
      r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
      if (w_tick) begin
        case (r_state)
          ST_START: r_state <= ST_DATA;
          ST_DATA: begin
            if (r_bit == r_last_bit) begin
              r_bit   <= '0;
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
            end
          end
          ST_PARITY: r_state <= ST_STOP;
          ST_STOP: begin
            if (w_last_stop) r_state <= ST_IDLE;
            else             r_bit   <= r_bit + 3'd1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_START:  w_line = 1'b0;
      ST_DATA:   w_line = r_shift[0];
      ST_PARITY: w_line = r_par_bit;
      default:   w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_tx <= 1'b1;
    else         r_tx <= w_line;
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         nbits;
    bit         par_en;
    bit         par_odd;
    bit         stop2;
  } sb_t;

  logic        clk;
  logic        resetn;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_data_bits;
  logic        cfg_parity_en;
  logic        cfg_parity_odd;
  logic        cfg_stop2;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [4:0]  fifo_level;
  logic        tx_busy;
  logic        uart_tx;

  sb_t sb [$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  mon_frames  = 0;
  bit  mon_active  = 0;
  int  busy_cycles = 0;
  int  busy_rises  = 0;

  uart_tx_stream #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cfg_div        (cfg_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .fifo_level     (fifo_level),
    .tx_busy        (tx_busy),
    .uart_tx        (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte; the expected frame is recorded with the config in force now.
  task automatic push(input logic [7:0] b);
    int  k;
    sb_t e;
    k = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && k < 20000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    assert (k < 20000) else begin
      n_fail++;
      $error("FAIL push_timeout: observed %0d cycles waiting, expected < 20000", k);
    end
    e.data    = b;
    e.div     = (cfg_div < 16'd2) ? 2 : int'(cfg_div);
    e.nbits   = 5 + int'(cfg_data_bits);
    e.par_en  = cfg_parity_en;
    e.par_odd = cfg_parity_odd;
    e.stop2   = cfg_stop2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while ((sb.size() != 0 || tx_busy || mon_active || fifo_level != 0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    assert (k < limit) else begin
      n_fail++;
      $error("FAIL idle_timeout: observed %0d cycles, expected < %0d", k, limit);
    end
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: on each start bit, pop the scoreboard and check every cycle
  // of the frame against a bit sequence built from the expected entry.
  initial begin : monitor
    sb_t         e;
    logic [11:0] bits;
    int          idx;
    int          len;
    logic        p;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (resetn && uart_tx === 1'b0) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_underflow: observed start bit with %0d queued, expected >0", sb.size());
        end
        if (sb.size() != 0) begin
          e    = sb.pop_front();
          bits = '0;
          p    = 1'b0;
          idx  = 1;
          for (int i = 0; i < e.nbits; i++) begin
            bits[idx] = e.data[i];
            p = p ^ e.data[i];
            idx++;
          end
          if (e.par_en) begin
            bits[idx] = p ^ e.par_odd;
            idx++;
          end
          bits[idx] = 1'b1;
          idx++;
          if (e.stop2) begin
            bits[idx] = 1'b1;
            idx++;
          end
          len        = idx * e.div;
          mon_active = 1'b1;
          aborted    = 1'b0;
          for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (!resetn) begin
              aborted = 1'b1;
              break;
            end
            check($sformatf("line_bit d=%02h c=%0d", e.data, c), 32'(uart_tx), 32'(bits[c / e.div]));
          end
          mon_active = 1'b0;
          if (!aborted) mon_frames++;
        end
      end
    end
  end

  initial begin : busy_meter
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_busy) busy_cycles++;
      if (tx_busy && !prev) busy_rises++;
      prev = tx_busy;
    end
  end

  initial begin
    resetn         = 1'b0;
    s_valid        = 1'b0;
    s_data         = '0;
    cfg_div        = 16'd4;
    cfg_data_bits  = 2'b11;
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    cfg_stop2      = 1'b0;

    // reset state
    #12;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_level",   32'(fifo_level), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, div 4, 0x55: latency and frame length
    busy_cycles = 0;
    busy_rises  = 0;
    push(8'h55);
    check("lat_n0_line", 32'(uart_tx), 32'd1);
    check("lat_n0_busy", 32'(tx_busy), 32'd0);
    @(posedge clk); #1;
    check("lat_n1_line", 32'(uart_tx), 32'd1);
    check("lat_n1_busy", 32'(tx_busy), 32'd1);
    @(posedge clk); #1;
    check("lat_n2_line", 32'(uart_tx), 32'd0);
    wait_idle(2000);
    check("busy_8n1_div4", 32'(busy_cycles), 32'd40);

    // 7E2 / 7O2, div 3, 0x41
    cfg_div = 16'd3; cfg_data_bits = 2'b10; cfg_parity_en = 1'b1;
    cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
    busy_cycles = 0;
    push(8'h41);
    wait_idle(2000);
    check("busy_7e2_div3", 32'(busy_cycles), 32'd33);
    cfg_parity_odd = 1'b1;
    busy_cycles = 0;
    push(8'h41);
    wait_idle(2000);
    check("busy_7o2_div3", 32'(busy_cycles), 32'd33);

    // 5O1, div 2, 0xFF
    cfg_div = 16'd2; cfg_data_bits = 2'b00; cfg_parity_en = 1'b1;
    cfg_parity_odd = 1'b1; cfg_stop2 = 1'b0;
    busy_cycles = 0;
    push(8'hFF);
    wait_idle(2000);
    check("busy_5o1_div2", 32'(busy_cycles), 32'd16);

    // back-to-back 8N1, div 5
    cfg_div = 16'd5; cfg_data_bits = 2'b11; cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    busy_cycles = 0;
    busy_rises  = 0;
    push(8'hA5);
    push(8'h3C);
    wait_idle(2000);
    check("busy_b2b_cycles", 32'(busy_cycles), 32'd100);
    check("busy_b2b_rises",  32'(busy_rises),  32'd1);

    // FIFO fill at div 1000; config changed mid-frame (div 0 -> 2, 8E1) for the rest
    cfg_div = 16'd1000;
    push(8'd11);
    @(posedge clk); #1;
    check("fill_first_popped", 32'(tx_busy), 32'd1);
    cfg_div = 16'd0;
    cfg_parity_en = 1'b1;
    for (int i = 1; i < 20; i++) begin
      push(8'(i * 37 + 11));
      if (i == 16) begin
        check("fill_level_full", 32'(fifo_level), 32'd16);
        check("fill_s_ready_low", 32'(s_ready), 32'd0);
      end
    end
    wait_idle(15000);

    // reset in the middle of DATA with a byte still queued
    cfg_div = 16'd4; cfg_data_bits = 2'b11; cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    push(8'hC3);
    push(8'h5A);
    repeat (10) @(negedge clk);
    check("pre_rst_level", 32'(fifo_level), 32'd1);
    check("pre_rst_busy",  32'(tx_busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_uart_tx", 32'(uart_tx), 32'd1);
    check("midrst_level",   32'(fifo_level), 32'd0);
    check("midrst_tx_busy", 32'(tx_busy), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    #2;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    busy_cycles = 0;
    push(8'h96);
    wait_idle(2000);
    check("busy_after_rst", 32'(busy_cycles), 32'd40);

    check("frames_done", 32'(mon_frames), 32'd27);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Parametrised, buffered UART transmitter and successor to the fixed 8N1 transmitter.
- Accepts bytes over a valid/ready stream into an internal FIFO.
- Serialises them with runtime-selectable baud divisor, data width (5-8), parity (none/even/odd) and stop bits (1/2).
- Frames go out back-to-back with no idle gap.
- Sits between the AXI4-Lite register block (config, TX data push) and the uart_tx pin.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of two, >=2
DIV_W, 16, width of baud divisor input
- 8-bit data is fixed. The clock-frequency parameter is dropped because the divisor is supplied at run time.

Ports:
clk  input  1  system clock
resetn  input  1  reset, asynchronous, active-low
cfg_div  input  DIV_W  clocks per bit; values <2 treated as 2
cfg_data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity_en  input  1  1=parity bit appended
cfg_parity_odd  input  1  1=odd, 0=even parity (ignored if !cfg_parity_en)
cfg_stop2  input  1  1=two stop bits
s_valid  input  1  byte available
s_data  input  8  byte; bits above data width ignored
s_ready  output  1  FIFO not full
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently stored
tx_busy  output  1  frame in progress
uart_tx  output  1  serial line, idle high

Behaviour:
- Reset (async, any time, including mid-frame):
  - uart_tx=1, tx_busy=0, fifo_level=0, s_ready=1 immediately.
  - FIFO contents discarded; FSM to IDLE.
- Push handshake:
  - Push occurs when s_valid && s_ready at a rising edge.
  - s_ready = (fifo_level != FIFO_DEPTH), registered-equivalent with no combinational path from s_valid.
  - Push into a full FIFO cannot occur.
  - No bypass path: data always enters the FIFO.
- Pop:
  - FSM pops only in IDLE or on the final cycle of the last stop bit.
  - Simultaneous push and pop leaves fifo_level unchanged.
- Config latch: cfg_* sampled at pop into a frame shadow register; changes mid-frame affect only the next frame.
- FSM states:
  - IDLE: uart_tx=1, tx_busy=0. If FIFO non-empty: pop, latch config, go to START.
  - START: uart_tx=0 for div cycles, then DATA.
  - DATA: LSB first, one bit per div cycles, n = 5..8 bits; then PARITY if enabled, else STOP.
  - PARITY: bit = XOR(data[n-1:0]) ^ parity_odd, for div cycles; then STOP.
  - STOP: uart_tx=1 for div cycles per stop bit (1 or 2). On the last cycle: if FIFO non-empty, pop and go to START (zero idle gap); else go to IDLE.
- Timing:
  - tx_busy=1 from the cycle after pop through the last stop-bit cycle.
  - tx_busy stays 1 across back-to-back frames.
  - Latency: push into empty idle FIFO at edge N -> uart_tx falls at edge N+2.
  - Frame length = div*(1+n+p+s) cycles exactly.
- Implementation: uart_tx is a registered output. The bit counter counts 0..div-1, width DIV_W; div is a 16-bit value, no overflow.

Decomposition:
- Package uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP); data-bits encoding constants; MIN_DIV=2.
- Sub-module sync_fifo (parametrised width 8, depth FIFO_DEPTH):
  - Provides full, empty and level outputs.
  - Read data is valid while not empty (first-word fall-through).

Test Plan:
- div=4, 8N1, push 0x55 to idle -> line low at N+2; bits 1,0,1,0,1,0,1,0 each 4 cycles; stop 4 cycles; tx_busy high 40 cycles.
- div=3, 7E2, push 0x41 -> 7 data bits 1,0,0,0,0,0,1; parity 0; two stop bits; frame 33 cycles. Same with odd parity -> parity bit 1.
- div=2, 5O1, push 0xFF -> data 1,1,1,1,1; parity 0 (five ones, odd); frame 16 cycles.
- div=5, 8N1, push 0xA5 and 0x3C on consecutive cycles -> second start bit immediately follows first stop bit; tx_busy never drops; total 100 cycles.
- div=1000, push 20 bytes continuously -> first popped; s_ready low after 17th accept with fifo_level=16; drains in order.
- cfg_div=0 -> 2-cycle bits. Change cfg mid-frame -> current frame unaffected. Assert resetn mid-DATA -> uart_tx=1 and fifo_level=0 same cycle; first frame after release is clean.
